ddr_init_seq_mr: RTL and testbench
==================================

Name: ddr_init_seq_mr

Overview:
Parametrised, synthesisable successor to the DDR4 controller power-up/reset initialisation sequencer. It drives CKE and the per-rank chip selects, and issues MRS and ZQCL to 1..RANKS ranks with programmable timing. After initialisation it stays resident and services runtime mode-register-write and ZQCS (short calibration) requests through req/ack handshakes. It sits between the controller's command scheduler and the DDR interface.

Parameters:
RANKS, 2, number of ranks (1..4); one cs_n bit per rank
T_CKE_LO, 8, CK_t cycles CKE is held low after reset_n deasserts
T_IS, 2, cycles from CKE high to the start of the tXPR window
T_XPR, 12, DES cycles before the first MRS
T_MRD, 8, DES cycles after each MRS except the last in a sequence
T_MOD, 24, DES cycles after the last MRS of a sequence
T_ZQINIT, 512, DES cycles after each init ZQCL
T_ZQCS, 64, DES cycles after each ZQCS
CNT_W, 10, timer width; must hold the largest T_* value

Ports:
CK_t input 1 clock; all logic on posedge
reset_n input 1 asynchronous active-low reset
mr_op input 7*14 init opcodes; MRn at bits [14n+13:14n]; sampled in the cycle each MRS is issued
cke output 1 clock enable
cs_n output RANKS per-rank chip select, active low
des_rdy output 1 DES window active
mrs_rdy output 1 MRS command cycle
zqcl_rdy output 1 ZQCL command cycle (long, init only)
zqcs_rdy output 1 ZQCS command cycle
mode_reg output 18 {1'b0, mr_sel[2:0], op[13:0]}; zero when not in an MRS cycle
ini_done output 1 initialisation complete; sticky until reset
mrw_req input 1 runtime MR write request (level; hold until ack)
mrw_sel input 3 MR index for the runtime write
mrw_op input 14 opcode for the runtime write
mrw_ack output 1 one-cycle pulse at the end of the T_MOD window
zqcs_req input 1 short-calibration request (level; hold until ack)
zqcs_ack output 1 one-cycle pulse at the end of the last rank's T_ZQCS window

Behaviour:
- Reset (asynchronous): cke=0, cs_n=all 1, every rdy=0, mode_reg=0, ini_done=0, both acks=0; FSM=RST_WAIT. Reset asserted in any state aborts the sequence immediately; the next deassertion restarts it from RST_WAIT.
- A "wait N" state lasts exactly N cycles; the timer loads N-1 on entry and the state exits when the timer reaches 0.
- RST_WAIT: wait T_CKE_LO, then cke=1 (registered; stays 1 until reset). CKE_IS: wait T_IS. XPR: wait T_XPR with des_rdy=1.
- MRS loop: order MR3, MR6, MR5, MR4, MR2, MR1, MR0. For each MR, ranks are visited 0..RANKS-1. Each command is one cycle: mrs_rdy=1, cs_n[r]=0 (other bits 1), des_rdy=0, mode_reg={0, idx, mr_op slice}. The command is followed by a gap with des_rdy=1, cs_n all 1, mode_reg=0. The gap is T_MRD cycles, except after the final (MR0, last rank) command, where it is T_MOD.
- ZQCL loop: for each rank, one cycle with zqcl_rdy=1 and cs_n[r]=0, then wait T_ZQINIT with des_rdy=1.
- Init ends in IDLE: ini_done=1, des_rdy=0, cs_n all 1.
- Total init length for RANKS=R: T_CKE_LO + T_IS + T_XPR + 7R + (7R-1)*T_MRD + T_MOD + R*(1+T_ZQINIT) cycles from the first posedge after reset_n rises to the ini_done=1 cycle (inclusive of that cycle).
- Requests are ignored (not lost) before ini_done=1. They are sampled only in IDLE.
- Both requests high in IDLE in the same cycle: ZQCS is served first, then MRW.
- MRW: the MRS is issued to every rank with the T_MRD gap between ranks and T_MOD after the last rank. mrw_sel and mrw_op are captured on the acceptance cycle. mrw_ack pulses in the last T_MOD cycle. Back to IDLE on the next cycle.
- ZQCS: one zqcs_rdy cycle plus a T_ZQCS wait per rank; zqcs_ack pulses in the final wait cycle.
- A requester must drop its req the cycle after ack. A req still high in IDLE is treated as a new request.
- At most one rdy flag is high in any cycle. des_rdy and any command rdy are mutually exclusive.

Test Plan:
- Defaults, RANKS=2: release reset_n, count cycles. Required: cke rises at cycle 8; first mrs_rdy at cycle 22 with mode_reg[16:14]=3; ini_done at cycle 22+14+13*8+24+2*513=1190; exactly 14 mrs_rdy and 2 zqcl_rdy pulses.
- mr_op with MR0 opcode 14'h0A55: the MR0 command cycles show mode_reg=18'h00A55 with cs_n=2'b10, then cs_n=2'b01.
- mrw_req raised during MRS loop with mrw_sel=1, mrw_op=14'h0123. Required: no action until IDLE; then mode_reg=18'h04123 to each rank; mrw_ack arrives 1+8+1+24 cycles after acceptance.
- zqcs_req and mrw_req rise together in IDLE. Required: 2 zqcs_rdy pulses, zqcs_ack, then the MRS pair and mrw_ack; no overlapping rdy flags.
- reset_n pulsed low mid-ZQCL wait. Required: all outputs return to reset values asynchronously; after release the full sequence repeats, and ini_done appears again after the same cycle count.
- RANKS=1, T_ZQINIT=1: sequence completes, cs_n is 1 bit, no timer underflow.

Source files
------------

// File: rtl/ddr_init_seq_mr.sv
// DDR4 power-up initialisation sequencer: CKE bring-up, per-rank MRS and ZQCL,
// then resident service of runtime mode-register writes and ZQCS requests.
module ddr_init_seq_mr #(
  parameter int RANKS    = 2,
  parameter int T_CKE_LO = 8,
  parameter int T_IS     = 2,
  parameter int T_XPR    = 12,
  parameter int T_MRD    = 8,
  parameter int T_MOD    = 24,
  parameter int T_ZQINIT = 512,
  parameter int T_ZQCS   = 64,
  parameter int CNT_W    = 10
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic [7*14-1:0]  mr_op,
  output logic             cke,
  output logic [RANKS-1:0] cs_n,
  output logic             des_rdy,
  output logic             mrs_rdy,
  output logic             zqcl_rdy,
  output logic             zqcs_rdy,
  output logic [17:0]      mode_reg,
  output logic             ini_done,
  input  logic             mrw_req,
  input  logic [2:0]       mrw_sel,
  input  logic [13:0]      mrw_op,
  output logic             mrw_ack,
  input  logic             zqcs_req,
  output logic             zqcs_ack
);

  localparam int RANK_W = (RANKS > 1) ? $clog2(RANKS) : 1;

  localparam logic [3:0] RST_WAIT  = 4'd0;
  localparam logic [3:0] CKE_IS    = 4'd1;
  localparam logic [3:0] XPR       = 4'd2;
  localparam logic [3:0] MRS_CMD   = 4'd3;
  localparam logic [3:0] MRS_GAP   = 4'd4;
  localparam logic [3:0] ZQCL_CMD  = 4'd5;
  localparam logic [3:0] ZQCL_WAIT = 4'd6;
  localparam logic [3:0] IDLE      = 4'd7;
  localparam logic [3:0] ZQCS_CMD  = 4'd8;
  localparam logic [3:0] ZQCS_WAIT = 4'd9;

  // Timers hold N-1 on entry so a wait state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_CKE_LO = CNT_W'(T_CKE_LO - 1);
  localparam logic [CNT_W-1:0] LD_IS     = CNT_W'(T_IS - 1);
  localparam logic [CNT_W-1:0] LD_XPR    = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD    = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQINIT = CNT_W'(T_ZQINIT - 1);
  localparam logic [CNT_W-1:0] LD_ZQCS   = CNT_W'(T_ZQCS - 1);
  localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(RANKS - 1);

  logic [3:0]        state;
  logic [CNT_W-1:0]  timer;
  logic [RANK_W-1:0] rank;
  logic [2:0]        step;
  logic              rt_mrw;
  logic [2:0]        mrw_sel_q;
  logic [13:0]       mrw_op_q;
  logic              cke_q;
  logic              done_q;

  logic              timer_zero;
  logic              last_rank;
  logic              last_cmd;
  logic [2:0]        cmd_sel;
  logic [13:0]       init_op;
  logic [13:0]       cmd_op;
  logic [RANKS-1:0]  rank_sel;

  // Init MRS order: MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  function automatic logic [2:0] mr_index(input logic [2:0] s);
    case (s)
      3'd0:    mr_index = 3'd3;
      3'd1:    mr_index = 3'd6;
      3'd2:    mr_index = 3'd5;
      3'd3:    mr_index = 3'd4;
      3'd4:    mr_index = 3'd2;
      3'd5:    mr_index = 3'd1;
      default: mr_index = 3'd0;
    endcase
  endfunction

  assign timer_zero = (timer == '0);
  assign last_rank  = (rank == LAST_RANK);
  assign last_cmd   = last_rank && (rt_mrw || step == 3'd6);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cmd_sel = rt_mrw ? mrw_sel_q : mr_index(step);
    init_op = '0;
    for (int i = 0; i < 7; i++)
      if (cmd_sel == 3'(i)) init_op = mr_op[14*i +: 14];
    cmd_op = rt_mrw ? mrw_op_q : init_op;
    for (int i = 0; i < RANKS; i++)
      rank_sel[i] = (rank == RANK_W'(i));
  end

  always_comb begin
    cs_n     = '1;
    des_rdy  = 1'b0;
    mrs_rdy  = 1'b0;
    zqcl_rdy = 1'b0;
    zqcs_rdy = 1'b0;
    mode_reg = '0;
    case (state)
      XPR, MRS_GAP, ZQCL_WAIT, ZQCS_WAIT: des_rdy = 1'b1;
      MRS_CMD: begin
        mrs_rdy  = 1'b1;
        cs_n     = ~rank_sel;
        mode_reg = {1'b0, cmd_sel, cmd_op};
      end
      ZQCL_CMD: begin
        zqcl_rdy = 1'b1;
        cs_n     = ~rank_sel;
      end
      ZQCS_CMD: begin
        zqcs_rdy = 1'b1;
        cs_n     = ~rank_sel;
      end
      default: ;
    endcase
  end

  assign cke      = cke_q;
  assign ini_done = done_q;
  assign mrw_ack  = (state == MRS_GAP) && rt_mrw && last_rank && timer_zero;
  assign zqcs_ack = (state == ZQCS_WAIT) && last_rank && timer_zero;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RST_WAIT;
      timer     <= LD_CKE_LO;
      rank      <= '0;
      step      <= '0;
      rt_mrw    <= 1'b0;
      mrw_sel_q <= '0;
      mrw_op_q  <= '0;
      cke_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (!timer_zero) timer <= timer - CNT_W'(1);
      case (state)
        RST_WAIT: if (timer_zero) begin
          state <= CKE_IS;
          timer <= LD_IS;
          cke_q <= 1'b1;
        end
        CKE_IS: if (timer_zero) begin
          state <= XPR;
          timer <= LD_XPR;
        end
        XPR: if (timer_zero) begin
          state  <= MRS_CMD;
          rank   <= '0;
          step   <= '0;
          rt_mrw <= 1'b0;
        end
        MRS_CMD: begin
          state <= MRS_GAP;
          timer <= last_cmd ? LD_MOD : LD_MRD;
        end
        MRS_GAP: if (timer_zero) begin
          if (last_cmd) begin
            rank   <= '0;
            rt_mrw <= 1'b0;
            state  <= rt_mrw ? IDLE : ZQCL_CMD;
          end else if (last_rank) begin
            rank  <= '0;
            step  <= step + 3'd1;
            state <= MRS_CMD;
          end else begin
            rank  <= rank + RANK_W'(1);
            state <= MRS_CMD;
          end
        end
        ZQCL_CMD: begin
          state <= ZQCL_WAIT;
          timer <= LD_ZQINIT;
        end
        ZQCL_WAIT: if (timer_zero) begin
          if (last_rank) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            rank  <= rank + RANK_W'(1);
            state <= ZQCL_CMD;
          end
        end
        // ZQCS has priority when both requests are pending.
        IDLE: begin
          if (zqcs_req) begin
            state <= ZQCS_CMD;
            rank  <= '0;
          end else if (mrw_req) begin
            state     <= MRS_CMD;
            rank      <= '0;
            rt_mrw    <= 1'b1;
            mrw_sel_q <= mrw_sel;
            mrw_op_q  <= mrw_op;
          end
        end
        ZQCS_CMD: begin
          state <= ZQCS_WAIT;
          timer <= LD_ZQCS;
        end
        ZQCS_WAIT: if (timer_zero) begin
          if (last_rank) begin
            state <= IDLE;
          end else begin
            rank  <= rank + RANK_W'(1);
            state <= ZQCS_CMD;
          end
        end
        default: state <= RST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_init_seq_mr.sv
// Directed bench for ddr_init_seq_mr: init timing, MR0 opcodes, runtime MRW/ZQCS,
// request arbitration, asynchronous reset mid-sequence and a single-rank build.
module tb_ddr_init_seq_mr;

  logic         CK_t = 1'b0;
  logic         reset_n = 1'b0;
  logic [97:0]  mr_op;
  logic         mrw_req = 1'b0, zqcs_req = 1'b0;
  logic [2:0]   mrw_sel = 3'd0;
  logic [13:0]  mrw_op = 14'd0;
  logic         cke, des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy, ini_done, mrw_ack, zqcs_ack;
  logic [1:0]   cs_n;
  logic [17:0]  mode_reg;

  logic         idle_req_1 = 1'b0;
  logic         cke_1, des_rdy_1, mrs_rdy_1, zqcl_rdy_1, zqcs_rdy_1, ini_done_1, mrw_ack_1, zqcs_ack_1;
  logic [0:0]   cs_n_1;
  logic [17:0]  mode_reg_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CK_t = ~CK_t;

  ddr_init_seq_mr dut (
    .CK_t(CK_t), .reset_n(reset_n), .mr_op(mr_op), .cke(cke), .cs_n(cs_n),
    .des_rdy(des_rdy), .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy), .zqcs_rdy(zqcs_rdy),
    .mode_reg(mode_reg), .ini_done(ini_done), .mrw_req(mrw_req), .mrw_sel(mrw_sel),
    .mrw_op(mrw_op), .mrw_ack(mrw_ack), .zqcs_req(zqcs_req), .zqcs_ack(zqcs_ack)
  );

  ddr_init_seq_mr #(.RANKS(1), .T_ZQINIT(1)) dut1 (
    .CK_t(CK_t), .reset_n(reset_n), .mr_op(mr_op), .cke(cke_1), .cs_n(cs_n_1),
    .des_rdy(des_rdy_1), .mrs_rdy(mrs_rdy_1), .zqcl_rdy(zqcl_rdy_1), .zqcs_rdy(zqcs_rdy_1),
    .mode_reg(mode_reg_1), .ini_done(ini_done_1), .mrw_req(idle_req_1), .mrw_sel(mrw_sel),
    .mrw_op(mrw_op), .mrw_ack(mrw_ack_1), .zqcs_req(idle_req_1), .zqcs_ack(zqcs_ack_1)
  );

  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  // Releases reset on a falling edge; cycle 0 is the period before the first posedge.
  task automatic release_and_count(input int stop_at, output int d0, output int d1, output int cyc);
    d0 = -1; d1 = -1; cyc = 0;
    @(negedge CK_t);
    reset_n = 1'b1;
    #1;
    while (d0 < 0 && cyc < stop_at) begin
      if (ini_done_1 && d1 < 0) d1 = cyc;
      if (ini_done) d0 = cyc;
      else if (cyc < stop_at - 1) begin step(); cyc++; end
      else cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    n_checks++; if (cke !== 1'b0) begin n_fail++; $display("FAIL reset_cke: got %b want 0", cke); end
    n_checks++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b want 11", cs_n); end
    n_checks++;
    if ({des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %b want 0000", {des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy});
    end
    n_checks++; if (mode_reg !== 18'h0) begin n_fail++; $display("FAIL reset_mode_reg: got %h want 0", mode_reg); end
    n_checks++;
    if ({ini_done, mrw_ack, zqcs_ack} !== 3'b0) begin
      n_fail++; $display("FAIL reset_done_acks: got %b want 000", {ini_done, mrw_ack, zqcs_ack});
    end
    n_checks++; if (cs_n_1 !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n_1rank: got %b want 1", cs_n_1); end
  endtask

  // Full init from reset release; an MRW request is raised in the MRS loop and must wait.
  task automatic test_init();
    int cyc = 0, first_cke = -1, first_mrs = -1, done_at = -1, d1_at = -1;
    int n_mrs = 0, n_zqcl = 0, mr0_hits = 0, overlaps = 0, early_ack = 0;
    logic [17:0] first_mode = '0;
    @(negedge CK_t);
    reset_n = 1'b1;
    #1;
    while (done_at < 0 && cyc < 2000) begin
      if (cyc == 30) begin mrw_req = 1'b1; mrw_sel = 3'd1; mrw_op = 14'h0123; end
      if (cke && first_cke < 0) first_cke = cyc;
      if (mrs_rdy) begin
        if (first_mrs < 0) begin first_mrs = cyc; first_mode = mode_reg; end
        if (mode_reg[16:14] == 3'd0) begin
          n_checks++;
          if (mode_reg !== 18'h00A55 || cs_n !== ((mr0_hits == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL mr0_cmd[%0d]: got mode_reg=%h cs_n=%b want 00a55/%b",
                               mr0_hits, mode_reg, cs_n, (mr0_hits == 0) ? 2'b10 : 2'b01);
          end
          mr0_hits++;
        end
        n_mrs++;
      end
      if (zqcl_rdy) n_zqcl++;
      if (mrw_ack || zqcs_ack) early_ack++;
      if ($countones({des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy}) > 1) overlaps++;
      if (ini_done_1 && d1_at < 0) d1_at = cyc;
      if (ini_done) done_at = cyc;
      else begin step(); cyc++; end
    end
    n_checks++; if (first_cke != 8) begin n_fail++; $display("FAIL init_cke_rise: got %0d want 8", first_cke); end
    n_checks++; if (first_mrs != 22) begin n_fail++; $display("FAIL init_first_mrs: got %0d want 22", first_mrs); end
    n_checks++; if (first_mode !== 18'h0C103) begin n_fail++; $display("FAIL init_first_mode: got %h want 0c103", first_mode); end
    n_checks++; if (done_at != 1190) begin n_fail++; $display("FAIL init_done_cycle: got %0d want 1190", done_at); end
    n_checks++; if (n_mrs != 14) begin n_fail++; $display("FAIL init_mrs_count: got %0d want 14", n_mrs); end
    n_checks++; if (n_zqcl != 2) begin n_fail++; $display("FAIL init_zqcl_count: got %0d want 2", n_zqcl); end
    n_checks++; if (mr0_hits != 2) begin n_fail++; $display("FAIL init_mr0_count: got %0d want 2", mr0_hits); end
    n_checks++; if (early_ack != 0) begin n_fail++; $display("FAIL init_req_ignored: got %0d acks want 0", early_ack); end
    n_checks++; if (overlaps != 0) begin n_fail++; $display("FAIL init_rdy_overlap: got %0d want 0", overlaps); end
    n_checks++; if (d1_at != 103) begin n_fail++; $display("FAIL init_1rank_done: got %0d want 103", d1_at); end
    n_checks++;
    if (ini_done_1 !== 1'b1 || cs_n_1 !== 1'b1 || des_rdy_1 !== 1'b0) begin
      n_fail++; $display("FAIL init_1rank_idle: got done=%b cs_n=%b des=%b want 1/1/0", ini_done_1, cs_n_1, des_rdy_1);
    end
  endtask

  // The pending MRW is accepted in the first IDLE cycle (offset 0 here).
  task automatic test_mrw();
    int off = 0, ack_at = -1, n_cmd = 0;
    int c_at[2] = '{-1, -1};
    logic [1:0]  c_cs[2];
    logic [17:0] c_mode[2];
    while (ack_at < 0 && off < 100) begin
      step(); off++;
      if (mrs_rdy) begin
        if (n_cmd < 2) begin c_at[n_cmd] = off; c_cs[n_cmd] = cs_n; c_mode[n_cmd] = mode_reg; end
        n_cmd++;
      end
      if (mrw_ack) ack_at = off;
    end
    step();
    mrw_req = 1'b0;
    n_checks++; if (ack_at != 34) begin n_fail++; $display("FAIL mrw_ack_latency: got %0d want 34", ack_at); end
    n_checks++; if (n_cmd != 2) begin n_fail++; $display("FAIL mrw_cmd_count: got %0d want 2", n_cmd); end
    n_checks++;
    if (c_at[0] != 1 || c_cs[0] !== 2'b10 || c_mode[0] !== 18'h04123) begin
      n_fail++; $display("FAIL mrw_rank0: got at=%0d cs_n=%b mode=%h want 1/10/04123", c_at[0], c_cs[0], c_mode[0]);
    end
    n_checks++;
    if (c_at[1] != 10 || c_cs[1] !== 2'b01 || c_mode[1] !== 18'h04123) begin
      n_fail++; $display("FAIL mrw_rank1: got at=%0d cs_n=%b mode=%h want 10/01/04123", c_at[1], c_cs[1], c_mode[1]);
    end
    n_checks++;
    if ({des_rdy, mrs_rdy, mrw_ack, ini_done} !== 4'b0001) begin
      n_fail++; $display("FAIL mrw_return_idle: got %b want 0001", {des_rdy, mrs_rdy, mrw_ack, ini_done});
    end
    step();
    n_checks++; if (mrs_rdy !== 1'b0) begin n_fail++; $display("FAIL mrw_no_repeat: got mrs_rdy=%b want 0", mrs_rdy); end
  endtask

  // Both requests rise together in IDLE: ZQCS on both ranks first, then the MRW.
  task automatic test_back_to_back();
    int off = 0, zq_ack_at = -1, mw_ack_at = -1, first_mrs = -1;
    int n_zqcs = 0, n_mrs = 0, overlaps = 0, n_zq_ack = 0;
    logic [17:0] mrs_mode = '0;
    logic drop_z = 1'b0;
    zqcs_req = 1'b1; mrw_req = 1'b1; mrw_sel = 3'd2; mrw_op = 14'h3FFF;
    while (mw_ack_at < 0 && off < 400) begin
      step(); off++;
      if (drop_z) begin zqcs_req = 1'b0; drop_z = 1'b0; end
      if (zqcs_rdy) n_zqcs++;
      if (zqcs_ack) begin zq_ack_at = off; n_zq_ack++; drop_z = 1'b1; end
      if (mrs_rdy) begin
        if (first_mrs < 0) begin first_mrs = off; mrs_mode = mode_reg; end
        n_mrs++;
      end
      if ($countones({des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy}) > 1) overlaps++;
      if (mrw_ack) mw_ack_at = off;
    end
    step();
    mrw_req = 1'b0;
    n_checks++; if (n_zqcs != 2) begin n_fail++; $display("FAIL b2b_zqcs_count: got %0d want 2", n_zqcs); end
    n_checks++;
    if (zq_ack_at != 130 || n_zq_ack != 1) begin
      n_fail++; $display("FAIL b2b_zqcs_ack: got at=%0d n=%0d want 130/1", zq_ack_at, n_zq_ack);
    end
    n_checks++;
    if (first_mrs != 132 || mrs_mode !== 18'h0BFFF) begin
      n_fail++; $display("FAIL b2b_first_mrs: got at=%0d mode=%h want 132/0bfff", first_mrs, mrs_mode);
    end
    n_checks++; if (n_mrs != 2) begin n_fail++; $display("FAIL b2b_mrs_count: got %0d want 2", n_mrs); end
    n_checks++; if (mw_ack_at != 165) begin n_fail++; $display("FAIL b2b_mrw_ack: got %0d want 165", mw_ack_at); end
    n_checks++; if (overlaps != 0) begin n_fail++; $display("FAIL b2b_rdy_overlap: got %0d want 0", overlaps); end
  endtask

  // Reset pulsed inside the second rank's ZQCL wait; the sequence must restart cleanly.
  task automatic test_reset_mid_zqcl();
    int d0, d1, cyc;
    reset_n = 1'b0;
    repeat (2) step();
    release_and_count(1001, d0, d1, cyc);
    n_checks++;
    if (cke !== 1'b1 || des_rdy !== 1'b1 || ini_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre_reset: got cke=%b des=%b done=%b at cycle %0d want 1/1/0", cke, des_rdy, ini_done, cyc);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cke, des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy, ini_done} !== 6'b0 || cs_n !== 2'b11 || mode_reg !== 18'h0) begin
      n_fail++; $display("FAIL mid_async_reset: got flags=%b cs_n=%b mode=%h want 000000/11/0",
                         {cke, des_rdy, mrs_rdy, zqcl_rdy, zqcs_rdy, ini_done}, cs_n, mode_reg);
    end
    n_checks++;
    if (ini_done_1 !== 1'b0 || cke_1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset_1rank: got done=%b cke=%b want 0/0", ini_done_1, cke_1);
    end
    step();
    release_and_count(2000, d0, d1, cyc);
    n_checks++; if (d0 != 1190) begin n_fail++; $display("FAIL mid_restart_done: got %0d want 1190", d0); end
    n_checks++; if (d1 != 103) begin n_fail++; $display("FAIL mid_restart_1rank: got %0d want 103", d1); end
  endtask

  initial begin
    for (int n = 0; n < 7; n++)
      mr_op[14*n +: 14] = (n == 0) ? 14'h0A55 : 14'(14'h0100 + n);
    test_reset();
    test_init();
    test_mrw();
    test_back_to_back();
    test_reset_mid_zqcl();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
